// File: rtl/ping_pong_ctrl.sv
// rtl/ping_pong_ctrl.sv - two-bank ping-pong buffer sequencing controller
module ping_pong_ctrl #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_bank,
    output logic          wr_frame_done,
    input  logic          rd_req,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          rd_bank,
    output logic          rd_valid,
    output logic          rd_last,
    output logic [1:0]    bank_full
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [1:0]    full_q, full_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
    logic          wr_at_last;
    logic          rd_at_last;

    // Handshakes: a bank is owned by the writer while empty and by the reader while full.
    always_comb begin
        wr_ready      = !full_q[wb_q];
        wr_en         = wr_valid && wr_ready;
        wr_at_last    = (wcnt_q == LAST);
        wr_frame_done = wr_en && wr_at_last;
        rd_en         = rd_req && full_q[rb_q];
        rd_at_last    = (rcnt_q == LAST);
        wr_addr       = wcnt_q;
        wr_bank       = wb_q;
        rd_addr       = rcnt_q;
        rd_bank       = rb_q;
        rd_valid      = rd_valid_q;
        rd_last       = rd_last_q;
        bank_full     = full_q;
    end

    // Next state: frame completions on both sides always target different banks, so both apply.
    always_comb begin
        wb_d       = wb_q;
        rb_d       = rb_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        full_d     = full_q;
        rd_valid_d = rd_en;
        rd_last_d  = rd_en && rd_at_last;
        if (wr_en) begin
            if (wr_at_last) begin
                wcnt_d       = '0;
                full_d[wb_q] = 1'b1;
                wb_d         = !wb_q;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end
        if (rd_en) begin
            if (rd_at_last) begin
                rcnt_d       = '0;
                full_d[rb_q] = 1'b0;
                rb_d         = !rb_q;
            end else begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial frame and overrides in-flight handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            full_q     <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            full_q     <= full_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// tb/tb_ping_pong_ctrl.sv - scoreboard testbench for ping_pong_ctrl at DEPTH=4
module tb_ping_pong_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_bank;
    logic          wr_frame_done;
    logic          rd_req;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          rd_bank;
    logic          rd_valid;
    logic          rd_last;
    logic [1:0]    bank_full;

    ping_pong_ctrl #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_bank       (wr_bank),
        .wr_frame_done (wr_frame_done),
        .rd_req        (rd_req),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_bank       (rd_bank),
        .rd_valid      (rd_valid),
        .rd_last       (rd_last),
        .bank_full     (bank_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int bank;
        int flag;
    } beat_t;

    beat_t exp_wr[$];
    beat_t exp_rd[$];
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_wr(input int bank, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = first + i;
            b.bank = bank;
            b.flag = (first + i == DEPTH - 1) ? 1 : 0;
            exp_wr.push_back(b);
        end
    endtask

    task automatic push_rd(input int bank, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = first + i;
            b.bank = bank;
            b.flag = (first + i == DEPTH - 1) ? 1 : 0;
            exp_rd.push_back(b);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write beat or read data.
    int cap_addr = 0;
    int cap_bank = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                cap_addr = 0;
                cap_bank = 0;
            end else begin
                if (wr_en) begin
                    if (exp_wr.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL wr_unexpected: wr_en=1 addr=%0d bank=%0d, expected no beat", wr_addr, wr_bank);
                    end else begin
                        beat_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", int'(wr_addr), e.addr);
                        chk("wr_bank", int'(wr_bank), e.bank);
                        chk("wr_frame_done", int'(wr_frame_done), e.flag);
                    end
                end
                if (rd_valid) begin
                    if (exp_rd.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL rd_unexpected: rd_valid=1, expected no read data");
                    end else begin
                        beat_t e;
                        e = exp_rd.pop_front();
                        chk("rd_addr", cap_addr, e.addr);
                        chk("rd_bank", cap_bank, e.bank);
                        chk("rd_last", int'(rd_last), e.flag);
                    end
                end
                if (rd_en) begin
                    cap_addr = int'(rd_addr);
                    cap_bank = int'(rd_bank);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_wr_ready", int'(wr_ready), 1);
        chk("reset_bank_full", int'(bank_full), 0);
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_wr_bank", int'(wr_bank), 0);
        chk("reset_rd_bank", int'(rd_bank), 0);
        chk("reset_wr_addr", int'(wr_addr), 0);

        // single frame through bank 0
        push_wr(0, 0, 4);
        wr_valid = 1'b1;
        repeat (4) step();
        wr_valid = 1'b0;
        chk("frame_bank_full", int'(bank_full), 1);
        chk("frame_wr_bank", int'(wr_bank), 1);
        push_rd(0, 0, 4);
        rd_req = 1'b1;
        repeat (4) step();
        rd_req = 1'b0;
        chk("drain_bank_full", int'(bank_full), 0);
        chk("drain_rd_bank", int'(rd_bank), 1);

        // starved read
        rd_req = 1'b1;
        #1;
        chk("starved_rd_en", int'(rd_en), 0);
        step();
        chk("starved_rd_valid", int'(rd_valid), 0);
        chk("starved_rd_addr", int'(rd_addr), 0);
        rd_req = 1'b0;

        // backpressure: 8 beats fill both banks, 9th refused
        push_wr(1, 0, 4);
        push_wr(0, 0, 4);
        wr_valid = 1'b1;
        repeat (8) step();
        chk("bp_wr_ready", int'(wr_ready), 0);
        chk("bp_wr_en", int'(wr_en), 0);
        chk("bp_wr_addr", int'(wr_addr), 0);
        chk("bp_bank_full", int'(bank_full), 3);
        step();
        wr_valid = 1'b0;

        // drain bank 1; writer stays blocked until after the last read
        push_rd(1, 0, 4);
        rd_req = 1'b1;
        repeat (3) step();
        chk("bp_hold_wr_ready", int'(wr_ready), 0);
        step();
        chk("bp_release_wr_ready", int'(wr_ready), 1);
        chk("bp_release_bank_full", int'(bank_full), 1);

        // concurrent swap: read bank 0 back-to-back while refilling bank 1
        push_rd(0, 0, 4);
        push_wr(1, 0, 4);
        wr_valid = 1'b1;
        repeat (3) step();
        chk("swap_pre_wr_addr", int'(wr_addr), 3);
        chk("swap_pre_rd_addr", int'(rd_addr), 3);
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("swap_bank_full", int'(bank_full), 2);
        chk("swap_wr_bank", int'(wr_bank), 0);
        chk("swap_rd_bank", int'(rd_bank), 1);
        chk("swap_wr_ready", int'(wr_ready), 1);

        // mid-operation reset with handshakes asserted during rst
        push_wr(0, 0, 2);
        push_rd(1, 0, 1);
        wr_valid = 1'b1;
        rd_req   = 1'b1;
        step();
        rd_req = 1'b0;
        step();
        rst    = 1'b1;
        rd_req = 1'b1;
        step();
        rst      = 1'b0;
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        chk("mrst_wr_addr", int'(wr_addr), 0);
        chk("mrst_rd_addr", int'(rd_addr), 0);
        chk("mrst_bank_full", int'(bank_full), 0);
        chk("mrst_rd_valid", int'(rd_valid), 0);
        chk("mrst_wr_bank", int'(wr_bank), 0);
        chk("mrst_rd_bank", int'(rd_bank), 0);
        chk("mrst_wr_ready", int'(wr_ready), 1);

        push_wr(0, 0, 4);
        wr_valid = 1'b1;
        repeat (4) step();
        wr_valid = 1'b0;
        chk("post_bank_full", int'(bank_full), 1);
        push_rd(0, 0, 4);
        rd_req = 1'b1;
        repeat (4) step();
        rd_req = 1'b0;
        repeat (3) step();
        chk("post_bank_empty", int'(bank_full), 0);
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
